vga_scanout: RTL and testbench

- Parametrised VGA timing generator and framebuffer scanout engine for the SPI-loaded screen RAM path.
- Generates a pixel-tick enable from the system clock, runs the h/v counters, and issues prefetched reads to a synchronous-read dual-port RAM.
- Serialises packed RAM words MSB-first into BPP-bit pixel indices, aligned to registered sync and active outputs.
- Adds configurable timing, sync polarity, multi-bit pixels, and a frame base address latched in vertical blank for page flipping.

---
 rtl/vga_scanout.sv | 196 +++++++++++++++++++
 tb/tb_vga_scanout.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA timing generator and framebuffer scanout engine.
// Divides clk down to a pixel tick, runs the h/v raster counters, prefetches
// packed pixel words from a synchronous-read RAM, and serialises them MSB-first
// into BPP-bit pixel indices. All outputs are registered and aligned to the tick.
module vga_scanout #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BPP      = 1,
    parameter bit SYNC_POL = 1'b0,
    parameter int ADDR_W   = 16,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic [BPP-1:0]    pix,
    output logic              frame_start,
    output logic              vblank_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PPW     = 8 / BPP;
    localparam int WORDS   = (H_ACTIVE * BPP) / 8;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int KW      = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HW-1:0]     H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_ACT_C   = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     HS_FIRST  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0]     PPW_MASK  = HW'(PPW - 1);
    localparam logic [VW-1:0]     V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_ACT_C   = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     VS_FIRST  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [KW-1:0]     K_LAST    = KW'(WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WORDS);

    logic [DIV_W-1:0]  div_q;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d, v_line_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [KW-1:0]     k_q, k_d;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic [7:0]        hold_q, hold_d;
    logic [7:0]        shift_q, shift_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              active_q, active_d;
    logic [BPP-1:0]    pix_q, pix_d;
    logic              frame_start_q, vblank_start_q;
    logic              tick_s, h_wrap_s, line_pref_s, word_pref_s;

    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign active       = active_q;
    assign pix          = pix_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

    // Next raster position, sync/active levels, prefetch decisions and pixel shift.
    always_comb begin
        tick_s   = (div_q == DIV_LAST);
        h_wrap_s = (h_q == H_LAST);
        h_d      = h_wrap_s ? {HW{1'b0}} : h_q + 1'b1;
        // v_line_d is the line that follows the current one
        v_line_d = (v_q == V_LAST) ? {VW{1'b0}} : v_q + 1'b1;
        v_d      = h_wrap_s ? v_line_d : v_q;

        hsync_d  = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_d  = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        active_d = (h_d < H_ACT_C) && (v_d < V_ACT_C);

        // Word 0 of the next visible line is fetched one pixel before the line starts
        line_pref_s = (h_d == H_LAST) && (v_line_d < V_ACT_C);
        // Word k+1 is fetched on the last pixel of word k
        word_pref_s = (h_d < H_ACT_C) && ((h_d & PPW_MASK) == PPW_MASK) &&
                      (k_q < K_LAST) && (v_q < V_ACT_C);

        line_base_d = line_base_q;
        k_d         = k_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        if (line_pref_s) begin
            line_base_d = (v_line_d == {VW{1'b0}}) ? base_q : line_base_q + LINE_STEP;
            k_d         = {KW{1'b0}};
            rd_en_d     = 1'b1;
            rd_addr_d   = line_base_d;
        end else if (word_pref_s) begin
            k_d       = k_q + 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = line_base_q + ADDR_W'(k_d);
        end else begin
            k_d = k_q;
        end

        // Bypass so a capture landing on the load edge is still seen
        hold_d = rd_pipe_q[RD_LAT-1] ? rd_data : hold_q;

        if (h_d < H_ACT_C) begin
            if ((h_d & PPW_MASK) == {HW{1'b0}}) begin
                shift_d = hold_d;
            end else begin
                shift_d = shift_q << BPP;
            end
        end else begin
            shift_d = shift_q;
        end

        pix_d = active_d ? shift_d[7 -: BPP] : {BPP{1'b0}};
    end

    // Read-data capture: delayed strobe lands the RAM word in the holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe_q <= {RD_LAT{1'b0}};
            hold_q    <= 8'h00;
        end else begin
            rd_pipe_q[0] <= rd_en_q;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
            hold_q <= hold_d;
        end
    end

    // Pixel-tick divider, raster counters, prefetch and registered video outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q          <= {DIV_W{1'b0}};
            h_q            <= H_ACT_C;
            v_q            <= V_LAST;
            base_q         <= {ADDR_W{1'b0}};
            line_base_q    <= {ADDR_W{1'b0}};
            k_q            <= {KW{1'b0}};
            shift_q        <= 8'h00;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= {ADDR_W{1'b0}};
            hsync_q        <= ~SYNC_POL;
            vsync_q        <= ~SYNC_POL;
            active_q       <= 1'b0;
            pix_q          <= {BPP{1'b0}};
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else if (tick_s) begin
            div_q          <= {DIV_W{1'b0}};
            h_q            <= h_d;
            v_q            <= v_d;
            line_base_q    <= line_base_d;
            k_q            <= k_d;
            shift_q        <= shift_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            active_q       <= active_d;
            pix_q          <= pix_d;
            frame_start_q  <= (h_d == {HW{1'b0}}) && (v_d == {VW{1'b0}});
            vblank_start_q <= (h_d == {HW{1'b0}}) && (v_d == V_ACT_C);
            // Page flip: the base only moves at the start of vertical blank
            if ((h_d == {HW{1'b0}}) && (v_d == V_ACT_C)) begin
                base_q <= fb_base;
            end else begin
                base_q <= base_q;
            end
        end else begin
            div_q          <= div_q + 1'b1;
            rd_en_q        <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout in a small raster (24x7 total, 16x4 visible),
// with one BPP=1 and one BPP=4 instance sharing clock, reset and frame base.
module tb_vga_scanout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] fb_base = 16'h0000;

    logic        rd_en1, rd_en4;
    logic [15:0] rd_addr1, rd_addr4;
    logic [7:0]  rd_data1, rd_data4;
    logic        hsync1, vsync1, active1, fs1, vb1;
    logic        hsync4, vsync4, active4, fs4, vb4;
    logic [0:0]  pix1;
    logic [3:0]  pix4;

    logic [7:0]  mem1 [0:511];
    logic [7:0]  mem4 [0:511];

    int checks = 0;
    int errors = 0;

    int       aq1[$];
    int       aq4[$];
    bit       pq1[$];
    bit [3:0] pq4[$];

    vga_scanout #(.CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .BPP(1),
                  .SYNC_POL(1'b0), .ADDR_W(16), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .fb_base(fb_base), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .hsync(hsync1), .vsync(vsync1), .active(active1),
        .pix(pix1), .frame_start(fs1), .vblank_start(vb1));

    vga_scanout #(.CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .BPP(4),
                  .SYNC_POL(1'b0), .ADDR_W(16), .RD_LAT(1)) dut4 (
        .clk(clk), .rst(rst), .fb_base(fb_base), .rd_en(rd_en4), .rd_addr(rd_addr4),
        .rd_data(rd_data4), .hsync(hsync4), .vsync(vsync4), .active(active4),
        .pix(pix4), .frame_start(fs4), .vblank_start(vb4));

    always #5 clk = ~clk;

    // Synchronous-read RAM models, one clk of latency.
    always @(posedge clk) begin
        if (rd_en1) rd_data1 <= mem1[rd_addr1[8:0]];
        if (rd_en4) rd_data4 <= mem4[rd_addr4[8:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected read addresses and pixels for one frame read from base b,
    // with the next frame's word-0 prefetch taken from base nb.
    task automatic prep_frame(input int b, input int nb);
        logic [7:0] w;
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 16; h++) begin
                w = mem1[(b + 2*v + h/8) % 512];
                pq1.push_back(w[7 - (h % 8)]);
                w = mem4[(b + 8*v + h/2) % 512];
                pq4.push_back((h % 2 == 0) ? w[7:4] : w[3:0]);
            end
        end
        for (int a = 1; a < 8; a++)  aq1.push_back(b + a);
        aq1.push_back(nb);
        for (int a = 1; a < 32; a++) aq4.push_back(b + a);
        aq4.push_back(nb);
    endtask

    // Wait (bounded) for the first read after reset; it must come 28 clk after
    // release (7 ticks to reach h=23 on the last line) from address 0.
    task automatic startup_check();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rd_en1 !== 1'b1 && n < 200);
        check("first_rd_cycle", n, 28);
        check("first_rd_addr1", rd_addr1, 0);
        check("first_rd_en4", rd_en4, 1);
        check("first_rd_addr4", rd_addr4, 0);
        repeat (4) @(negedge clk);
    endtask

    // Walk one whole frame starting at the frame_start sample, checking every clk.
    // Optionally drive fb_base to fv at raster position (fh, fvv).
    task automatic run_frame(input bit do_flip, input int fv, input int fh, input int fvv);
        int       rd1 = 0;
        int       rd4 = 0;
        int       h, v;
        bit       tk, ea;
        bit       e1 = 1'b0;
        bit [3:0] e4 = 4'h0;
        for (int c = 0; c < 672; c++) begin
            if (c > 0) @(negedge clk);
            h  = (c / 4) % 24;
            v  = (c / 4) / 24;
            tk = (c % 4 == 0);
            ea = (h < 16) && (v < 4);
            if (tk) begin
                if (ea) begin
                    e1 = pq1.pop_front();
                    e4 = pq4.pop_front();
                end else begin
                    e1 = 1'b0;
                    e4 = 4'h0;
                end
            end
            check("hsync1", hsync1, !(h >= 18 && h < 21));
            check("vsync1", vsync1, !(v == 5));
            check("active1", active1, ea);
            check("pix1", pix1, e1);
            check("hsync4", hsync4, !(h >= 18 && h < 21));
            check("vsync4", vsync4, !(v == 5));
            check("active4", active4, ea);
            check("pix4", pix4, e4);
            check("frame_start", fs1, tk && h == 0 && v == 0);
            check("vblank_start", vb1, tk && h == 0 && v == 4);
            check("frame_start4", fs4, tk && h == 0 && v == 0);
            check("rd_en1", rd_en1, tk && ((h == 23 && (v == 6 || v < 3)) || (h == 7 && v < 4)));
            check("rd_en4", rd_en4, tk && ((h == 23 && (v == 6 || v < 3)) || (h < 15 && h % 2 == 1 && v < 4)));
            if (rd_en1 === 1'b1) begin
                rd1++;
                if (aq1.size() > 0) check("rd_addr1", rd_addr1, aq1.pop_front());
                else check("rd_addr1_extra", rd_addr1, 32'hFFFF_FFFF);
            end
            if (rd_en4 === 1'b1) begin
                rd4++;
                if (aq4.size() > 0) check("rd_addr4", rd_addr4, aq4.pop_front());
                else check("rd_addr4_extra", rd_addr4, 32'hFFFF_FFFF);
            end
            if (do_flip && tk && h == fh && v == fvv) fb_base = fv[15:0];
        end
        check("rd_count1", rd1, 8);
        check("rd_count4", rd4, 32);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem1[i] = 8'((i * 37 + 165 + (i / 256) * 90) % 256);
            mem4[i] = 8'((i * 53 + 60 + (i / 256) * 77) % 256);
        end
        mem1[0] = 8'hA5;
        mem4[0] = 8'h3C;
        mem4[1] = 8'h7E;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hsync", hsync1, 1);
        check("rst_vsync", vsync1, 1);
        check("rst_active", active1, 0);
        check("rst_pix1", pix1, 0);
        check("rst_pix4", pix4, 0);
        check("rst_rd_en", rd_en1, 0);
        check("rst_fs", fs1, 0);
        check("rst_vb", vb1, 0);
        rst = 1'b0;

        // Frame 0 from base 0; fb_base moves to 0x100 in the middle of line 2
        startup_check();
        prep_frame(0, 32'h100);
        run_frame(1'b1, 32'h100, 5, 2);

        // Frame 1 from 0x100; a change after vblank must not reach the next prefetch
        prep_frame(32'h100, 32'h100);
        run_frame(1'b1, 32'h180, 5, 5);

        // Mid-frame reset at (5,1) of frame 2
        check("frame2_start", fs1, 1);
        repeat (29 * 4) @(negedge clk);
        check("pre_rst_active", active1, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_hsync1", hsync1, 1);
        check("mid_rst_vsync1", vsync1, 1);
        check("mid_rst_active1", active1, 0);
        check("mid_rst_pix1", pix1, 0);
        check("mid_rst_rd_en1", rd_en1, 0);
        check("mid_rst_active4", active4, 0);
        check("mid_rst_pix4", pix4, 0);
        check("mid_rst_rd_en4", rd_en4, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        aq1.delete();
        aq4.delete();
        pq1.delete();
        pq4.delete();

        // Recovery frame reads from base 0; vblank then latches 0x180
        startup_check();
        prep_frame(0, 32'h180);
        run_frame(1'b0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
